// File: rtl/spi_slave_byte_if.sv
// SPI pin and local byte-handshake signals of spi_slave_byte.
// Defining SPI_SLV_OVR_CNT_EN adds the ovr_cnt_o overrun counter.
interface spi_slave_byte_if;
    logic       spi_clk_i;
    logic       spi_nss_i;
    logic       spi_mosi_i;
    logic       spi_miso_o;
    logic       spi_miso_oe_o;
    logic       cfg_cpol_i;
    logic       cfg_cpha_i;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ready_i;
    logic       ovr_o;
    logic       ovr_clr_i;
    logic       busy_o;
`ifdef SPI_SLV_OVR_CNT_EN
    logic [7:0] ovr_cnt_o;
`endif

    modport slave (
        input  spi_clk_i, spi_nss_i, spi_mosi_i, cfg_cpol_i, cfg_cpha_i,
        input  tx_data_i, tx_valid_i, rx_ready_i, ovr_clr_i,
        output spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        output ovr_o, busy_o
`ifdef SPI_SLV_OVR_CNT_EN
        , output ovr_cnt_o
`endif
    );

    modport master (
        output spi_clk_i, spi_nss_i, spi_mosi_i, cfg_cpol_i, cfg_cpha_i,
        output tx_data_i, tx_valid_i, rx_ready_i, ovr_clr_i,
        input  spi_miso_o, spi_miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
        input  ovr_o, busy_o
`ifdef SPI_SLV_OVR_CNT_EN
        , input ovr_cnt_o
`endif
    );
endinterface

// File: rtl/spi_slave_byte.sv
// Byte-oriented SPI slave, all four CPOL/CPHA modes, MSB first, oversampled in hclk.
// Defining SPI_SLV_OVR_CNT_EN adds a saturating overrun counter (ovr_cnt_o).
module spi_slave_byte #(
    parameter logic [7:0] TX_IDLE     = 8'hFF,
    parameter int         SYNC_STAGES = 2
) (
    input  logic            hclk,
    input  logic            hreset,
    spi_slave_byte_if.slave bus
);
    typedef enum logic {IDLE, SEL} state_t;
    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, mosi_sync;
    logic       sclk_s, nss_s, mosi_s, sclk_q, nss_q;
    logic       nss_fall, nss_rise, lead, trail, sample, shift, byte_done, overrun;
    logic       load_tx, leave;
    logic [7:0] tx_shift, tx_next, rx_data;
    logic [6:0] rx_shift;
    logic [2:0] bit_cnt;
    logic       reload_pend, miso, miso_oe, rx_valid, ovr;

    // sclk is folded with cpol before syncing: idle reads 0, so lead = rise, trail = fall
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            sclk_sync <= '0;
            nss_sync  <= '1;
            mosi_sync <= '0;
            sclk_q    <= 1'b0;
            nss_q     <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clk_i ^ bus.cfg_cpol_i};
            nss_sync  <= {nss_sync[SYNC_STAGES-2:0], bus.spi_nss_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi_i};
            sclk_q    <= sclk_s;
            nss_q     <= nss_s;
        end
    end

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign nss_s     = nss_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign nss_fall  = ~nss_s & nss_q;
    assign nss_rise  = nss_s & ~nss_q;
    assign lead      = ~nss_s & sclk_s & ~sclk_q;
    assign trail     = ~nss_s & ~sclk_s & sclk_q;
    assign sample    = (state == SEL) & (bus.cfg_cpha_i ? trail : lead);
    assign shift     = (state == SEL) & (bus.cfg_cpha_i ? lead : trail);
    assign byte_done = sample & (bit_cnt == 3'd7);
    assign overrun   = byte_done & rx_valid & ~bus.rx_ready_i;
    assign tx_next   = bus.tx_valid_i ? bus.tx_data_i : TX_IDLE;

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_tx   = 1'b0;
        leave     = 1'b0;
        case (state)
            IDLE: if (nss_fall) begin
                state_nxt = SEL;
                load_tx   = 1'b1;
            end
            SEL: if (nss_rise) begin
                state_nxt = IDLE;
                leave     = 1'b1;
            end else if (bus.cfg_cpha_i ? byte_done : (shift & reload_pend)) begin
                load_tx = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            tx_shift    <= '0;
            rx_shift    <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
        end else if (leave) begin
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
        end else begin
            if (state == IDLE && load_tx) begin
                bit_cnt <= '0;
                miso_oe <= 1'b1;
            end
            if (sample) begin
                rx_shift <= {rx_shift[5:0], mosi_s};
                bit_cnt  <= bit_cnt + 3'd1;
                if (!bus.cfg_cpha_i && bit_cnt == 3'd7) reload_pend <= 1'b1;
            end
            // CPHA=1 reloads on the 8th sample but waits for the next lead to drive bit7
            if (load_tx) begin
                tx_shift    <= tx_next;
                reload_pend <= 1'b0;
                if (state == IDLE || !bus.cfg_cpha_i) miso <= tx_next[7];
            end else if (shift) begin
                miso     <= bus.cfg_cpha_i ? tx_shift[7] : tx_shift[6];
                tx_shift <= {tx_shift[6:0], 1'b0};
            end
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
            ovr      <= 1'b0;
        end else begin
            if (byte_done) begin
                rx_data  <= {rx_shift, mosi_s};
                rx_valid <= 1'b1;
            end else if (rx_valid && bus.rx_ready_i) begin
                rx_valid <= 1'b0;
            end
            if (overrun)            ovr <= 1'b1;
            else if (bus.ovr_clr_i) ovr <= 1'b0;
        end
    end

`ifdef SPI_SLV_OVR_CNT_EN
    logic [7:0] ovr_cnt;
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset)                         ovr_cnt <= '0;
        else if (bus.ovr_clr_i)             ovr_cnt <= {7'd0, overrun};
        else if (overrun && ovr_cnt != '1)  ovr_cnt <= ovr_cnt + 8'd1;
    end
    assign bus.ovr_cnt_o = ovr_cnt;
`endif

    assign bus.spi_miso_o    = miso;
    assign bus.spi_miso_oe_o = miso_oe;
    assign bus.tx_ready_o    = load_tx & bus.tx_valid_i;
    assign bus.rx_data_o     = rx_data;
    assign bus.rx_valid_o    = rx_valid;
    assign bus.ovr_o         = ovr;
    assign bus.busy_o        = (state == SEL) && (bit_cnt != 3'd0);
endmodule
